bcd_to_bin_seq: RTL and testbench

Sequential decimal-to-binary converter. It takes six packed BCD digits, such as a score or high-score entered or stored in decimal form, and produces the 20-bit binary value. This is the inverse of the binary-to-digit split that drives the six seven-segment displays.

---
 rtl/sevenseg_pkg.sv | 11 +
 rtl/bcd_to_bin_seq_if.sv | 24 ++
 rtl/bcd_to_bin_seq_mac.sv | 21 ++
 rtl/bcd_to_bin_seq.sv | 83 ++++++++
 tb/tb_bcd_to_bin_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment score path: digit
// count, binary width, BCD digit type and converter FSM states.
package sevenseg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 20;

  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result handshake bundle for the BCD-to-binary converter.
// master = digit source + result consumer, slave = converter.
interface bcd_to_bin_seq_if #(
  parameter int NUM_DIGITS = sevenseg_pkg::NUM_DIGITS,
  parameter int BIN_W      = sevenseg_pkg::BIN_W
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [BIN_W-1:0]        value;
  logic                    err;
  logic                    busy;

  modport master (
    output in_valid, digits_in, out_ready,
    input  in_ready, out_valid, value, err, busy
  );
  modport slave (
    input  in_valid, digits_in, out_ready,
    output in_ready, out_valid, value, err, busy
  );
endinterface

// File: rtl/bcd_to_bin_seq_mac.sv
// One decimal step: acc*10 + digit (shift-add in BIN_W+4 bits, then
// truncated), plus a flag for a non-decimal digit.
module bcd_mac_x10
  import sevenseg_pkg::*;
#(
  parameter int BIN_W = sevenseg_pkg::BIN_W
) (
  input  logic [BIN_W-1:0] acc,
  input  bcd_t             digit,
  output logic [BIN_W-1:0] acc_next,
  output logic             digit_bad
);
  logic [BIN_W+3:0] wide, prod;
  logic             unused_hi;

  assign wide      = {4'b0, acc};
  assign prod      = (wide << 3) + (wide << 1) + {{BIN_W{1'b0}}, digit};
  assign acc_next  = prod[BIN_W-1:0];
  assign unused_hi = ^prod[BIN_W+3:BIN_W];
  assign digit_bad = digit > BCD_MAX;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: captures NUM_DIGITS digits, folds
// them MSB first at one digit per clock, then holds the result until taken.
module bcd_to_bin_seq
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = sevenseg_pkg::NUM_DIGITS,
  parameter int BIN_W      = sevenseg_pkg::BIN_W
) (
  input logic            clk,
  input logic            rst_n,
  bcd_to_bin_seq_if.slave bus
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t                 state;
  bcd_t [NUM_DIGITS-1:0]  dig;
  logic [BIN_W-1:0]       acc, acc_next;
  logic [CW-1:0]          cnt;
  logic                   err_acc, digit_bad, err_now;
  bcd_t                   cur;

  // Counter runs upward while digits are consumed from the top down.
  assign cur     = dig[LAST - cnt];
  assign err_now = err_acc | digit_bad;

  bcd_mac_x10 #(.BIN_W(BIN_W)) u_mac (
    .acc      (acc),
    .digit    (cur),
    .acc_next (acc_next),
    .digit_bad(digit_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dig           <= '0;
      acc           <= '0;
      cnt           <= '0;
      err_acc       <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.value     <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dig          <= bus.digits_in;
            acc          <= '0;
            cnt          <= '0;
            err_acc      <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= CONVERT;
          end
        end
        CONVERT: begin
          acc     <= acc_next;
          err_acc <= err_now;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.value     <= err_now ? '0 : acc_next;
            bus.err       <= err_now;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; a new request waits for the next cycle.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized and directed bench for bcd_to_bin_seq against a decimal
// reference model.
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.NUM_DIGITS(6), .BIN_W(20)) bus ();
  bcd_to_bin_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void model(input logic [23:0] d, output int v, output bit e);
    v = 0;
    e = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      int dd;
      dd = int'(d[4*k +: 4]);
      if (dd > 9) e = 1'b1;
      v = v * 10 + dd;
    end
    if (e) v = 0;
  endfunction

  function automatic logic [23:0] rand_digits(input bit allow_bad);
    logic [23:0] d;
    int r;
    d = '0;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 9);
      if (allow_bad && $urandom_range(0, 7) == 0) r = $urandom_range(10, 15);
      d[4*k +: 4] = r[3:0];
    end
    return d;
  endfunction

  // Presents a request and returns #1 after the accept edge.
  task automatic drive_req(input logic [23:0] d);
    int n;
    @(negedge clk);
    bus.digits_in = d;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL req_timeout: in_ready=%0b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input bit scramble, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (scramble) bus.digits_in = 24'($urandom);
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.out_valid) begin
      total++;
      $display("FAIL result_timeout: out_valid=%0b want 1", bus.out_valid);
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.digits_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); else pass_cnt++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.value !== 20'd0) $display("FAIL rst_value: got %0d want 0", bus.value); else pass_cnt++;
    total++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %0b want 0", bus.err); else pass_cnt++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    drive_req(24'h000146);
    wait_result(1'b0, lat);
    total++; if (lat != 6) $display("FAIL basic_latency: got %0d want 6", lat); else pass_cnt++;
    total++; if (bus.value !== 20'd146) $display("FAIL basic_value: got %0d want 146", bus.value); else pass_cnt++;
    total++; if (bus.err !== 1'b0) $display("FAIL basic_err: got %0b want 0", bus.err); else pass_cnt++;
    total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL basic_done_flags: busy=%0b in_ready=%0b want 1/0", bus.busy, bus.in_ready); else pass_cnt++;
    accept_result();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_release: in_ready=%0b out_valid=%0b busy=%0b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy); else pass_cnt++;
    total++; if (bus.value !== 20'd146) $display("FAIL basic_value_hold: got %0d want 146", bus.value); else pass_cnt++;
  endtask

  task automatic test_patterns();
    logic [23:0] pat [4] = '{24'h999999, 24'h000000, 24'h12A456, 24'h000007};
    logic [19:0] ev  [4] = '{20'hF423F, 20'd0, 20'd0, 20'd7};
    bit          ee  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive_req(pat[i]);
      wait_result(1'b0, lat);
      total++; if (bus.value !== ev[i]) $display("FAIL pat_value[%0h]: got %0h want %0h", pat[i], bus.value, ev[i]); else pass_cnt++;
      total++; if (bus.err !== ee[i]) $display("FAIL pat_err[%0h]: got %0b want %0b", pat[i], bus.err, ee[i]); else pass_cnt++;
      accept_result();
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    int v, lat;
    bit e;
    for (int i = 0; i < 24; i++) begin
      d = rand_digits(1'b1);
      model(d, v, e);
      drive_req(d);
      wait_result(1'b0, lat);
      total++; if (bus.value !== v[19:0] || bus.err !== e || lat != 6)
        $display("FAIL rand[%0h]: value=%0d err=%0b lat=%0d want %0d/%0b/6", d, bus.value, bus.err, lat, v, e); else pass_cnt++;
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] d;
    int v, lat;
    bit e;
    d = rand_digits(1'b0);
    model(d, v, e);
    drive_req(d);
    wait_result(1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid  = i[0];
      bus.digits_in = 24'($urandom);
      @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b1 || bus.value !== v[19:0] || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: out_valid=%0b value=%0d in_ready=%0b want 1/%0d/0", i, bus.out_valid, bus.value, bus.in_ready, v); else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    accept_result();
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1/0", bus.in_ready, bus.out_valid); else pass_cnt++;
    drive_req(24'h000042);
    wait_result(1'b0, lat);
    total++; if (bus.value !== 20'd42) $display("FAIL bp_next: got %0d want 42", bus.value); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_back_to_back();
    int t0, t1, lat;
    drive_req(24'h000555);
    t0 = cyc;
    wait_result(1'b0, lat);
    accept_result();
    drive_req(24'h000888);
    t1 = cyc;
    total++; if (t1 - t0 != 8) $display("FAIL b2b_interval: got %0d want 8", t1 - t0); else pass_cnt++;
    wait_result(1'b0, lat);
    total++; if (bus.value !== 20'd888) $display("FAIL b2b_value: got %0d want 888", bus.value); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_digits_change();
    int lat;
    drive_req(24'h054321);
    wait_result(1'b1, lat);
    total++; if (bus.value !== 20'd54321 || bus.err !== 1'b0)
      $display("FAIL capture: value=%0d err=%0b want 54321/0", bus.value, bus.err); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    drive_req(24'h987654);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.value !== 20'd0 || bus.busy !== 1'b0)
      $display("FAIL midrst_state: in_ready=%0b out_valid=%0b value=%0d busy=%0b want 1/0/0/0", bus.in_ready, bus.out_valid, bus.value, bus.busy); else pass_cnt++;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL midrst_no_result: out_valid seen=%0b want 0", seen); else pass_cnt++;
    drive_req(24'h000321);
    wait_result(1'b0, lat);
    total++; if (bus.value !== 20'd321 || lat != 6) $display("FAIL midrst_next: value=%0d lat=%0d want 321/6", bus.value, lat); else pass_cnt++;
    accept_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_digits_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
